// File: rtl/mt2015_q4_pipe.sv
// rtl/mt2015_q4_pipe.sv - two-stage per-lane logic pipeline with valid/ready handshakes and saturating ones counter
//
// Parameters:
//   WIDTH     number of independent bit lanes (1..64)
//   CNT_W     width of the ones counter (4..32)
// Ports:
//   clk       rising-edge clock
//   areset_n  asynchronous active-low reset
//   in_valid  upstream operand set valid
//   in_ready  block can accept an operand set this cycle
//   x, y      lane operands
//   mode      function select, captured with the operands
//   out_valid z holds a result (driven straight from the output register)
//   out_ready downstream accepts the result this cycle
//   z         lane results
//   cnt_clr   synchronous clear of ones_cnt (clear happens before this cycle's add)
//   ones_cnt  saturating count of 1 bits over all delivered results

module mt2015_q4_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((64'd1 << CNT_W) - 64'd1);

    // Stage 1: captured operands
    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [1:0]       s1_mode;

    // Stage 2 is the output register itself (out_valid / z)
    logic             in_hs;
    logic             out_hs;
    logic             s1_adv;

    logic [WIDTH-1:0] lane_a;
    logic [WIDTH-1:0] lane_b;
    logic [WIDTH-1:0] z_next;

    logic [PC_W-1:0]  pc_z;
    logic [CNT_W-1:0] cnt_base;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    assign out_hs   = out_valid & out_ready;
    // S1 moves into S2 when S2 is empty or is being drained this same cycle
    assign s1_adv   = s1_valid & (~out_valid | out_ready);
    // Room exists if either stage is empty, or the whole pipe shifts this cycle
    assign in_ready = ~s1_valid | ~out_valid | out_ready;
    assign in_hs    = in_valid & in_ready;

    always_comb begin
        lane_a = (s1_x ^ s1_y) & s1_x;
        lane_b = ~(s1_x ^ s1_y);
        z_next = '0;
        case (s1_mode)
            2'd0:    z_next = (lane_a | lane_b) ^ (lane_a & lane_b);
            2'd1:    z_next = lane_a;
            2'd2:    z_next = lane_b;
            default: z_next = s1_x ^ s1_y;
        endcase
    end

    always_comb begin
        pc_z = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc_z = pc_z + PC_W'(z[i]);
        end
    end

    // Clear is applied first so a clear on a delivering beat loads that beat's popcount
    always_comb begin
        cnt_base = cnt_clr ? '0 : ones_cnt;
        cnt_sum  = SUM_W'(cnt_base) + SUM_W'(pc_z);
        cnt_next = cnt_base;
        if (out_hs) begin
            cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= '0;
        end else begin
            if (in_hs) begin
                s1_valid <= 1'b1;
                s1_x     <= x;
                s1_y     <= y;
                s1_mode  <= mode;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out_valid <= 1'b0;
            z         <= '0;
        end else begin
            if (s1_adv) begin
                out_valid <= 1'b1;
                z         <= z_next;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            ones_cnt <= '0;
        end else begin
            ones_cnt <= cnt_next;
        end
    end

endmodule

// File: doc/mt2015_q4_pipe.md
MT2015_Q4_PIPE -- requirements
Module: mt2015_q4_pipe

Interface
REQ-001 Parameter WIDTH, default 8, number of independent bit lanes (1..64).
REQ-002 Parameter CNT_W, default 16, width of the result ones-counter (4..32).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port areset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  upstream presents a valid operand set.
REQ-006 Port in_ready  output  1  block accepts the operand set this cycle.
REQ-007 Port x  input  WIDTH  lane operand x.
REQ-008 Port y  input  WIDTH  lane operand y.
REQ-009 Port mode  input  2  function select, sampled with the operands.
REQ-010 Port out_valid  output  1  z holds a valid result.
REQ-011 Port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 Port z  output  WIDTH  lane results.
REQ-013 Port cnt_clr  input  1  synchronous clear of ones_cnt.
REQ-014 Port ones_cnt  output  CNT_W  saturating count of 1 bits in all delivered results.

Function
REQ-015 Per lane i, A[i] SHALL be (x[i] XOR y[i]) AND x[i]; B[i] SHALL be NOT (x[i] XOR y[i]).
REQ-016 mode 0 SHALL give z[i] = (A|B) XOR (A&B), i.e. x[i] OR NOT y[i]; mode 1 SHALL give A[i]; mode 2 SHALL give B[i]; mode 3 SHALL give x[i] XOR y[i].
REQ-017 Input handshake occurs when in_valid and in_ready are both 1; output handshake when out_valid and out_ready are both 1.
REQ-018 Datapath SHALL be two register stages: S1 captures x, y, mode on input handshake; S2 captures computed z from S1 when S1 advances.
REQ-019 S1 SHALL advance when S1 valid and (S2 empty or output handshake this cycle).
REQ-020 in_ready SHALL equal (S1 empty) OR (S2 empty) OR out_ready; combinational path out_ready to in_ready is permitted.
REQ-021 Latency with out_ready held 1: result of a handshake at edge N SHALL be on z with out_valid=1 after edge N+2; throughput one result per cycle.
REQ-022 While out_valid=1 and out_ready=0, z and out_valid SHALL hold unchanged; no result SHALL be dropped or duplicated.
REQ-023 Results SHALL leave in acceptance order; mode SHALL apply per transaction, so mode changes between beats affect only later beats.
REQ-024 out_valid and z SHALL be driven directly from S2 registers.
REQ-025 On each output handshake ones_cnt SHALL add popcount(z), saturating at 2^CNT_W-1 (no wrap).
REQ-026 cnt_clr=1 SHALL set ones_cnt to 0 at the next edge; cnt_clr coincident with an output handshake SHALL load popcount(z) of that beat (clear first, then add).
REQ-027 in_valid=0 SHALL leave S1 unchanged, except S1 empties when it advances into S2.

Reset
REQ-028 areset_n=0 SHALL immediately clear S1 valid, S2 valid, out_valid=0, z=0, ones_cnt=0, independent of clk.
REQ-029 Reset asserted mid-transfer SHALL discard all in-flight beats; in_ready SHALL be 1 while reset is asserted and on the first cycle after release.
REQ-030 Reset release SHALL be synchronised externally; first handshake is permitted on the first edge after areset_n rises.

Verification
REQ-031 WIDTH=8, out_ready=1, mode 0, x=8'hF0, y=8'hCC -> z=8'hF3 after 2 edges, ones_cnt=6.
REQ-032 Back-to-back beats modes 1,2,3 with x=8'hA5, y=8'h3C -> z=8'h81, 8'h66, 8'h99 on consecutive cycles, in order; ones_cnt accumulates 2+4+4.
REQ-033 out_ready=0 for 5 cycles with 3 beats offered -> 2 accepted, in_ready=0 thereafter, z stable; release -> both delivered in order, none lost.
REQ-034 CNT_W=4, repeated mode 0 beats x=8'hFF, y=8'h00 -> ones_cnt saturates at 15 and stays there; cnt_clr with a handshake -> ones_cnt=8.
REQ-035 areset_n pulled low between edges with both stages full -> out_valid, z, ones_cnt 0 immediately; after release the next beat has latency 2 and correct z.
REQ-036 Random in_valid/out_ready, 10k beats, all modes, WIDTH 1 and 64 -> output stream equals scoreboard model of REQ-016 and REQ-025.
